mc_control_fsm: RTL and testbench

- Main multicycle control state machine for the MIPS datapath.
- Decodes the latched instruction opcode and sequences fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and muxes, including the Beq/Bne qualifiers consumed by the Branches block. Branches combines them with Flag_ALU to form the conditional PC write.
- Supports a memory-ready handshake so that slow memory can stall fetch and load/store accesses.

---
 rtl/mc_control_fsm_if.sv | 32 +++
 rtl/mc_control_fsm.sv | 147 ++++++++++++++
 tb/tb_mc_control_fsm.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the MIPS datapath.
// The master side is the FSM, which drives the enables and mux selects.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       PCWrite;
    logic       Beq;
    logic       Bne;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, PCWrite, Beq, Bne, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, PCWrite, Beq, Bne, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux; mem_ready stalls memory states.
module mc_control_fsm #(
    parameter int ST_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    mc_control_fsm_if.master    bus,
    output logic [ST_W-1:0]     state_o
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        R_WB      = 4'd8,
        EXEC_I    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        ILLEGAL   = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t state, next;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    assign state_o = ST_W'(state);

    always_comb begin
        next           = IDLE;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUOp      = 3'b000;
        bus.PCSource   = 2'b00;
        bus.PCWrite    = 1'b0;
        bus.Beq        = 1'b0;
        bus.Bne        = 1'b0;
        bus.illegal_op = 1'b0;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                // PC+4 is formed every cycle; only the accepted fetch commits it
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                next        = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_R:                    next = EXEC_R;
                    OP_LW, OP_SW:            next = MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI: next = EXEC_I;
                    OP_BEQ, OP_BNE:          next = BRANCH;
                    OP_J:                    next = JUMP;
                    default:                 next = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                next        = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                bus.IorD = 1'b1;
                next     = bus.mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                next         = FETCH;
            end
            MEM_WRITE: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                next         = bus.mem_ready ? FETCH : MEM_WRITE;
            end
            EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b010;
                next        = R_WB;
            end
            R_WB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                next         = FETCH;
            end
            EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (bus.opcode)
                    OP_ANDI: bus.ALUOp = 3'b011;
                    OP_ORI:  bus.ALUOp = 3'b100;
                    default: bus.ALUOp = 3'b000;
                endcase
                next = I_WB;
            end
            I_WB: begin
                bus.RegWrite = 1'b1;
                next         = FETCH;
            end
            BRANCH: begin
                // PC write is conditional and formed downstream from Beq/Bne
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = 3'b001;
                bus.PCSource = 2'b01;
                bus.Beq      = (bus.opcode == OP_BEQ);
                bus.Bne      = (bus.opcode == OP_BNE);
                next         = FETCH;
            end
            JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                next         = FETCH;
            end
            ILLEGAL: begin
                bus.illegal_op = 1'b1;
                next           = FETCH;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: directed per-cycle vectors push the
// expected state/control word; a negedge monitor pops and compares.
module tb_mc_control_fsm;
    logic clk = 1'b0;
    logic reset;
    logic [3:0] state_o;
    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
    } exp_t;
    exp_t q[$];

    mc_control_fsm_if bus ();
    mc_control_fsm #(.ST_W(4)) dut (.clk(clk), .reset(reset), .bus(bus), .state_o(state_o));

    always #5 clk = ~clk;

    // Packs control outputs in a fixed order for single-word comparison.
    function automatic logic [17:0] ctl(input logic iord, mw, irw, rd, m2r, rw, asa,
                                        input logic [1:0] asb, input logic [2:0] op,
                                        input logic [1:0] pcs, input logic pcw, beq, bne, ill);
        return {iord, mw, irw, rd, m2r, rw, asa, asb, op, pcs, pcw, beq, bne, ill};
    endfunction

    logic [17:0] K_IDLE, K_F1, K_F0, K_DEC, K_MADDR, K_MRD, K_MWB, K_MWR, K_EXR, K_RWB;
    logic [17:0] K_ADDI, K_ANDI, K_ORI, K_IWB, K_BEQ, K_BNE, K_JMP, K_ILL;

    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input logic [3:0] est, input logic [17:0] ec);
        reset = r;
        bus.opcode = op;
        bus.mem_ready = mr;
        q.push_back('{st: est, ctl: ec});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = q.pop_front();
            act = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.PCWrite,
                   bus.Beq, bus.Bne, bus.illegal_op};
            checks++;
            if (state_o !== e.st) begin
                failures++;
                $display("FAIL state t=%0t got=%0d want=%0d", $time, state_o, e.st);
            end
            checks++;
            if (act !== e.ctl) begin
                failures++;
                $display("FAIL ctl st=%0d t=%0t got=%b want=%b", e.st, $time, act, e.ctl);
            end
        end
    end

    initial begin
        K_IDLE  = '0;
        K_F1    = ctl(0,0,1,0,0,0,0,2'b01,3'b000,2'b00,1,0,0,0);
        K_F0    = ctl(0,0,0,0,0,0,0,2'b01,3'b000,2'b00,0,0,0,0);
        K_DEC   = ctl(0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,0,0,0);
        K_MADDR = ctl(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0,0,0);
        K_MRD   = ctl(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0);
        K_MWB   = ctl(0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0,0,0);
        K_MWR   = ctl(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0);
        K_EXR   = ctl(0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0,0,0);
        K_RWB   = ctl(0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0,0,0);
        K_ADDI  = ctl(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0,0,0);
        K_ANDI  = ctl(0,0,0,0,0,0,1,2'b10,3'b011,2'b00,0,0,0,0);
        K_ORI   = ctl(0,0,0,0,0,0,1,2'b10,3'b100,2'b00,0,0,0,0);
        K_IWB   = ctl(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0,0,0);
        K_BEQ   = ctl(0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0,1,0,0);
        K_BNE   = ctl(0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0,0,1,0);
        K_JMP   = ctl(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0,0,0);
        K_ILL   = ctl(0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,1);

        reset = 1'b1; bus.opcode = 6'h00; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        // reset held, then released: IDLE with all outputs low
        step(1, 6'h23, 1, 4'd0, K_IDLE);
        step(1, 6'h23, 1, 4'd0, K_IDLE);
        step(0, 6'h23, 1, 4'd0, K_IDLE);
        // lw with two MEM_READ stall cycles
        step(0, 6'h23, 1, 4'd1, K_F1);
        step(0, 6'h23, 1, 4'd2, K_DEC);
        step(0, 6'h23, 1, 4'd3, K_MADDR);
        step(0, 6'h23, 0, 4'd4, K_MRD);
        step(0, 6'h23, 0, 4'd4, K_MRD);
        step(0, 6'h23, 1, 4'd4, K_MRD);
        step(0, 6'h23, 1, 4'd5, K_MWB);
        // beq then bne
        step(0, 6'h04, 1, 4'd1, K_F1);
        step(0, 6'h04, 1, 4'd2, K_DEC);
        step(0, 6'h04, 1, 4'd11, K_BEQ);
        step(0, 6'h05, 1, 4'd1, K_F1);
        step(0, 6'h05, 1, 4'd2, K_DEC);
        step(0, 6'h05, 1, 4'd11, K_BNE);
        // sw with three FETCH stall cycles
        step(0, 6'h2B, 0, 4'd1, K_F0);
        step(0, 6'h2B, 0, 4'd1, K_F0);
        step(0, 6'h2B, 0, 4'd1, K_F0);
        step(0, 6'h2B, 1, 4'd1, K_F1);
        step(0, 6'h2B, 1, 4'd2, K_DEC);
        step(0, 6'h2B, 1, 4'd3, K_MADDR);
        step(0, 6'h2B, 1, 4'd6, K_MWR);
        // sw with one MEM_WRITE stall cycle
        step(0, 6'h2B, 1, 4'd1, K_F1);
        step(0, 6'h2B, 1, 4'd2, K_DEC);
        step(0, 6'h2B, 1, 4'd3, K_MADDR);
        step(0, 6'h2B, 0, 4'd6, K_MWR);
        step(0, 6'h2B, 1, 4'd6, K_MWR);
        // illegal opcode
        step(0, 6'h3F, 1, 4'd1, K_F1);
        step(0, 6'h3F, 1, 4'd2, K_DEC);
        step(0, 6'h3F, 1, 4'd13, K_ILL);
        // andi, ori, addi
        step(0, 6'h0C, 1, 4'd1, K_F1);
        step(0, 6'h0C, 1, 4'd2, K_DEC);
        step(0, 6'h0C, 1, 4'd9, K_ANDI);
        step(0, 6'h0C, 1, 4'd10, K_IWB);
        step(0, 6'h0D, 1, 4'd1, K_F1);
        step(0, 6'h0D, 1, 4'd2, K_DEC);
        step(0, 6'h0D, 1, 4'd9, K_ORI);
        step(0, 6'h0D, 1, 4'd10, K_IWB);
        step(0, 6'h08, 1, 4'd1, K_F1);
        step(0, 6'h08, 1, 4'd2, K_DEC);
        step(0, 6'h08, 1, 4'd9, K_ADDI);
        step(0, 6'h08, 1, 4'd10, K_IWB);
        // jump, then a full R-type
        step(0, 6'h02, 1, 4'd1, K_F1);
        step(0, 6'h02, 1, 4'd2, K_DEC);
        step(0, 6'h02, 1, 4'd12, K_JMP);
        step(0, 6'h00, 1, 4'd1, K_F1);
        step(0, 6'h00, 1, 4'd2, K_DEC);
        step(0, 6'h00, 1, 4'd7, K_EXR);
        step(0, 6'h00, 1, 4'd8, K_RWB);
        // R-type aborted by reset during EXEC_R: no R_WB write
        step(0, 6'h00, 1, 4'd1, K_F1);
        step(0, 6'h00, 1, 4'd2, K_DEC);
        step(1, 6'h00, 1, 4'd7, K_EXR);
        step(0, 6'h00, 1, 4'd0, K_IDLE);
        step(0, 6'h00, 1, 4'd1, K_F1);
        step(0, 6'h00, 1, 4'd2, K_DEC);
        // reset during a FETCH stall
        step(0, 6'h23, 1, 4'd7, K_EXR);
        step(0, 6'h23, 0, 4'd8, K_RWB);
        step(1, 6'h23, 0, 4'd1, K_F0);
        step(0, 6'h23, 1, 4'd0, K_IDLE);
        step(0, 6'h23, 1, 4'd1, K_F1);
        done = 1'b1;
    end

    initial begin
        fork
            wait (done && q.size() == 0);
            #20000;
        join_any
        disable fork;
        @(posedge clk); #1;
        checks++;
        if (!(done && q.size() == 0)) begin
            failures++;
            $display("FAIL timeout done=%0d pending=%0d want done=1 pending=0", done, q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
